alu_issue_stage: RTL and testbench

Execute-issue pipeline register sitting directly upstream of the ALU. Accepts a decoded RV32I-style arithmetic instruction from decode, resolves operands (register file, immediate, PC, forwarded results), maps opcode/funct fields onto the ALU's 3-bit operation code, and presents a registered, valid/ready-handshaked operand bundle to the ALU. It also covers what the ALU cannot do alone: SUB becomes an ADD of the negated operand, and shift amounts are masked.

---
 rtl/alu_issue_stage_pkg.sv | 24 ++
 rtl/alu_issue_stage_operand_forward.sv | 30 +++
 rtl/alu_issue_stage.sv | 182 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage and the ALU itself:
// ALU operation encodings and the RV32I opcodes this stage accepts.
package alu_issue_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SLL  = 3'd1,
    ALU_SLT  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SR   = 3'd5,
    ALU_OR   = 3'd6,
    ALU_AND  = 3'd7
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SR      = 3'd5;

endpackage

// File: rtl/alu_issue_stage_operand_forward.sv
// Resolves one source operand: x0 reads as zero, then the EX-stage result,
// then the WB-stage result, then register-file data. EX is younger, so it wins.
module operand_forward #(
  parameter int WORD_SIZE      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [WORD_SIZE-1:0]      rf_data,
  input  logic                      ex_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic [WORD_SIZE-1:0]      ex_data,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [WORD_SIZE-1:0]      wb_data,
  output logic [WORD_SIZE-1:0]      value
);

  // Priority select of the freshest copy of the source register.
  always_comb begin
    value = rf_data;
    if (rs == '0) begin
      value = '0;
    end else if (ex_valid && (ex_rd == rs)) begin
      value = ex_data;
    end else if (wb_valid && (wb_rd == rs)) begin
      value = wb_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue register in front of the ALU. Resolves operands, maps the
// instruction onto an ALU op, folds SUB into ADD of the negated operand,
// masks shift amounts, and holds the bundle under valid/ready backpressure.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int WORD_SIZE      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [6:0]                in_opcode,
  input  logic [2:0]                in_funct3,
  input  logic                      in_funct7_5,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
  input  logic [WORD_SIZE-1:0]      in_rs1_data,
  input  logic [WORD_SIZE-1:0]      in_rs2_data,
  input  logic [WORD_SIZE-1:0]      in_imm,
  input  logic [WORD_SIZE-1:0]      in_pc,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      fwd_ex_valid,
  input  logic                      fwd_wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_ex_rd,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_wb_rd,
  input  logic [WORD_SIZE-1:0]      fwd_ex_data,
  input  logic [WORD_SIZE-1:0]      fwd_wb_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_SIZE-1:0]      out_a,
  output logic [WORD_SIZE-1:0]      out_b,
  output logic [2:0]                out_op,
  output logic                      out_arith,
  output logic                      out_illegal,
  output logic [REG_ADDR_WIDTH-1:0] out_rd
);

  localparam int SHAMT_W = $clog2(WORD_SIZE);

  // Two's-complement negation so the ALU only ever needs an adder.
  function automatic logic [WORD_SIZE-1:0] negate(input logic [WORD_SIZE-1:0] x);
    logic signed [WORD_SIZE-1:0] s;
    s = $signed(x);
    return $unsigned(-s);
  endfunction

  // Keep only the legal shift distance; upper operand bits forced to zero.
  function automatic logic [WORD_SIZE-1:0] mask_shamt(input logic [WORD_SIZE-1:0] x);
    return {{(WORD_SIZE-SHAMT_W){1'b0}}, x[SHAMT_W-1:0]};
  endfunction

  logic [WORD_SIZE-1:0] rs1_val_p0;
  logic [WORD_SIZE-1:0] rs2_val_p0;
  logic [WORD_SIZE-1:0] a_p0;
  logic [WORD_SIZE-1:0] b_p0;
  alu_op_e              op_p0;
  logic                 arith_p0;
  logic                 illegal_p0;

  logic                      vld_p1;
  logic [WORD_SIZE-1:0]      a_p1;
  logic [WORD_SIZE-1:0]      b_p1;
  logic [2:0]                op_p1;
  logic                      arith_p1;
  logic                      illegal_p1;
  logic [REG_ADDR_WIDTH-1:0] rd_p1;

  operand_forward #(
    .WORD_SIZE      (WORD_SIZE),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs1 (
    .rs       (in_rs1),
    .rf_data  (in_rs1_data),
    .ex_valid (fwd_ex_valid),
    .ex_rd    (fwd_ex_rd),
    .ex_data  (fwd_ex_data),
    .wb_valid (fwd_wb_valid),
    .wb_rd    (fwd_wb_rd),
    .wb_data  (fwd_wb_data),
    .value    (rs1_val_p0)
  );

  operand_forward #(
    .WORD_SIZE      (WORD_SIZE),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs2 (
    .rs       (in_rs2),
    .rf_data  (in_rs2_data),
    .ex_valid (fwd_ex_valid),
    .ex_rd    (fwd_ex_rd),
    .ex_data  (fwd_ex_data),
    .wb_valid (fwd_wb_valid),
    .wb_rd    (fwd_wb_rd),
    .wb_data  (fwd_wb_data),
    .value    (rs2_val_p0)
  );

  // Stage p0: decode opcode/funct into ALU operands and op code.
  always_comb begin
    a_p0       = '0;
    b_p0       = '0;
    op_p0      = ALU_ADD;
    arith_p0   = 1'b0;
    illegal_p0 = 1'b0;
    case (in_opcode)
      OPC_OP: begin
        a_p0  = rs1_val_p0;
        b_p0  = rs2_val_p0;
        op_p0 = alu_op_e'(in_funct3);
        if (in_funct7_5) begin
          if (in_funct3 == F3_ADD_SUB) begin
            b_p0 = negate(rs2_val_p0);
          end else if (in_funct3 == F3_SR) begin
            arith_p0 = 1'b1;
          end else begin
            illegal_p0 = 1'b1;
          end
        end
      end
      OPC_OP_IMM: begin
        a_p0  = rs1_val_p0;
        b_p0  = in_imm;
        op_p0 = alu_op_e'(in_funct3);
        if (in_funct3 == F3_SR) begin
          arith_p0 = in_funct7_5;
        end
      end
      OPC_LUI: begin
        b_p0 = in_imm;
      end
      OPC_AUIPC: begin
        a_p0 = in_pc;
        b_p0 = in_imm;
      end
      default: begin
        illegal_p0 = 1'b1;
      end
    endcase
    if ((op_p0 == ALU_SLL) || (op_p0 == ALU_SR)) begin
      b_p0 = mask_shamt(b_p0);
    end
  end

  assign in_ready = !vld_p1 || out_ready;

  // Stage p1: registered bundle with valid/ready hold, flush and reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      a_p1       <= '0;
      b_p1       <= '0;
      op_p1      <= '0;
      arith_p1   <= 1'b0;
      illegal_p1 <= 1'b0;
      rd_p1      <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (in_valid && in_ready) begin
      vld_p1     <= 1'b1;
      a_p1       <= a_p0;
      b_p1       <= b_p0;
      op_p1      <= op_p0;
      arith_p1   <= arith_p0;
      illegal_p1 <= illegal_p0;
      rd_p1      <= in_rd;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_a       = a_p1;
  assign out_b       = b_p1;
  assign out_op      = op_p1;
  assign out_arith   = arith_p1;
  assign out_illegal = illegal_p1;
  assign out_rd      = rd_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions push their
// hand-computed bundle; a monitor pops on every ALU-side transfer.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        arith;
    logic        illegal;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic        fwd_ex_valid, fwd_wb_valid;
  logic [4:0]  fwd_ex_rd, fwd_wb_rd;
  logic [31:0] fwd_ex_data, fwd_wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_op;
  logic        out_arith, out_illegal;
  logic [4:0]  out_rd;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  localparam logic [6:0] OP = 7'h33, OPI = 7'h13, LUI = 7'h37, AUIPC = 7'h17, BR = 7'h63;

  alu_issue_stage #(.WORD_SIZE(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
    .fwd_ex_valid(fwd_ex_valid), .fwd_wb_valid(fwd_wb_valid),
    .fwd_ex_rd(fwd_ex_rd), .fwd_wb_rd(fwd_wb_rd),
    .fwd_ex_data(fwd_ex_data), .fwd_wb_data(fwd_wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_arith(out_arith),
    .out_illegal(out_illegal), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                              input logic arith, input logic ill, input logic [4:0] rd);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.arith = arith; e.illegal = ill; e.rd = rd;
    return e;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid && ready.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        got = mk(out_a, out_b, out_op, out_arith, out_illegal, out_rd);
        if (sb.size() == 0) begin
          chk("unexpected_output", 80'(got), 80'(0));
        end else begin
          e = sb.pop_front();
          chk("bundle", 80'(got), 80'(e));
        end
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 after the instruction is accepted.
  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rs1, input logic [31:0] d1,
                      input logic [4:0] rs2, input logic [31:0] d2,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                      input exp_t e, input bit push);
    bit ok;
    in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7_5 = f7;
    in_rs1 = rs1; in_rs1_data = d1; in_rs2 = rs2; in_rs2_data = d2;
    in_imm = imm; in_pc = pc; in_rd = rd;
    if (push) sb.push_back(e);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    if (!ok) chk("accept_timeout", 80'(0), 80'(1));
    @(posedge clk); #2;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic clr_fwd();
    fwd_ex_valid = 1'b0; fwd_wb_valid = 1'b0;
    fwd_ex_rd = '0; fwd_wb_rd = '0; fwd_ex_data = '0; fwd_wb_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_opcode = '0; in_funct3 = '0; in_funct7_5 = 1'b0; in_rs1 = '0; in_rs2 = '0;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_pc = '0; in_rd = '0;
    clr_fwd();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 80'({out_valid, out_a, out_b, out_op, out_arith, out_illegal, out_rd}), 80'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 80'(in_ready), 80'(1));
    @(posedge clk); #2;

    // Back-to-back stream with out_ready held high.
    send(OP, 3'd0, 1'b0, 5'd1, 32'd10, 5'd2, 32'd32, 32'h0, 32'h0, 5'd3,
         mk(32'd10, 32'd32, 3'd0, 1'b0, 1'b0, 5'd3), 1'b1);
    send(OP, 3'd0, 1'b1, 5'd1, 32'd10, 5'd2, 32'd5, 32'h0, 32'h0, 5'd3,
         mk(32'd10, 32'hFFFF_FFFB, 3'd0, 1'b0, 1'b0, 5'd3), 1'b1);
    send(OP, 3'd5, 1'b1, 5'd1, 32'h8000_0000, 5'd2, 32'h23, 32'h0, 32'h0, 5'd4,
         mk(32'h8000_0000, 32'd3, 3'd5, 1'b1, 1'b0, 5'd4), 1'b1);
    send(OP, 3'd5, 1'b0, 5'd1, 32'h8000_0000, 5'd2, 32'h25, 32'h0, 32'h0, 5'd4,
         mk(32'h8000_0000, 32'd5, 3'd5, 1'b0, 1'b0, 5'd4), 1'b1);
    send(OP, 3'd1, 1'b0, 5'd1, 32'h1, 5'd2, 32'hFFFF_FFE4, 32'h0, 32'h0, 5'd6,
         mk(32'h1, 32'd4, 3'd1, 1'b0, 1'b0, 5'd6), 1'b1);
    send(OP, 3'd4, 1'b0, 5'd1, 32'h0000_F0F0, 5'd2, 32'hFFFF_0000, 32'h0, 32'h0, 5'd5,
         mk(32'h0000_F0F0, 32'hFFFF_0000, 3'd4, 1'b0, 1'b0, 5'd5), 1'b1);
    send(OP, 3'd2, 1'b1, 5'd1, 32'd7, 5'd2, 32'd9, 32'h0, 32'h0, 5'd8,
         mk(32'd7, 32'd9, 3'd2, 1'b0, 1'b1, 5'd8), 1'b1);

    // Forwarding: EX beats WB, WB beats RF, x0 always zero.
    fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd4; fwd_ex_data = 32'hAA;
    fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'hBB;
    send(OP, 3'd0, 1'b0, 5'd4, 32'h11, 5'd5, 32'd7, 32'h0, 32'h0, 5'd9,
         mk(32'hAA, 32'd7, 3'd0, 1'b0, 1'b0, 5'd9), 1'b1);
    fwd_ex_rd = 5'd7; fwd_wb_rd = 5'd6; fwd_wb_data = 32'hCC;
    send(OP, 3'd6, 1'b0, 5'd6, 32'h22, 5'd7, 32'h33, 32'h0, 32'h0, 5'd10,
         mk(32'hCC, 32'hAA, 3'd6, 1'b0, 1'b0, 5'd10), 1'b1);
    fwd_ex_rd = 5'd0; fwd_ex_data = 32'h55; fwd_wb_rd = 5'd0; fwd_wb_data = 32'h66;
    send(OP, 3'd0, 1'b0, 5'd0, 32'h99, 5'd0, 32'h77, 32'h0, 32'h0, 5'd11,
         mk(32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 5'd11), 1'b1);
    clr_fwd();

    // Immediate forms, LUI/AUIPC and an unsupported opcode.
    send(LUI, 3'd0, 1'b0, 5'd1, 32'hDEAD, 5'd2, 32'hBEEF, 32'h1234_5000, 32'h0, 5'd12,
         mk(32'h0, 32'h1234_5000, 3'd0, 1'b0, 1'b0, 5'd12), 1'b1);
    send(AUIPC, 3'd0, 1'b0, 5'd1, 32'hDEAD, 5'd2, 32'hBEEF, 32'h1000, 32'h100, 5'd13,
         mk(32'h100, 32'h1000, 3'd0, 1'b0, 1'b0, 5'd13), 1'b1);
    send(BR, 3'd5, 1'b1, 5'd1, 32'hDEAD, 5'd2, 32'hBEEF, 32'h40, 32'h200, 5'd14,
         mk(32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 5'd14), 1'b1);
    send(OPI, 3'd5, 1'b1, 5'd1, 32'h40, 5'd2, 32'hBEEF, 32'h405, 32'h0, 5'd15,
         mk(32'h40, 32'd5, 3'd5, 1'b1, 1'b0, 5'd15), 1'b1);
    send(OPI, 3'd1, 1'b0, 5'd1, 32'h3, 5'd2, 32'hBEEF, 32'h21, 32'h0, 5'd16,
         mk(32'h3, 32'd1, 3'd1, 1'b0, 1'b0, 5'd16), 1'b1);
    send(OPI, 3'd0, 1'b1, 5'd1, 32'h30, 5'd2, 32'hBEEF, 32'hFFFF_FFF0, 32'h0, 5'd17,
         mk(32'h30, 32'hFFFF_FFF0, 3'd0, 1'b0, 1'b0, 5'd17), 1'b1);
    idle();
    idle();

    // Backpressure: A held for 3 cycles while B waits, then both drain in order.
    out_ready = 1'b0;
    send(OP, 3'd7, 1'b0, 5'd1, 32'h0F0F, 5'd2, 32'h00FF, 32'h0, 32'h0, 5'd18,
         mk(32'h0F0F, 32'h00FF, 3'd7, 1'b0, 1'b0, 5'd18), 1'b1);
    in_valid = 1'b1; in_opcode = OP; in_funct3 = 3'd3; in_funct7_5 = 1'b0;
    in_rs1 = 5'd1; in_rs1_data = 32'h5; in_rs2 = 5'd2; in_rs2_data = 32'h6; in_rd = 5'd19;
    sb.push_back(mk(32'h5, 32'h6, 3'd3, 1'b0, 1'b0, 5'd19));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_in_ready", 80'(in_ready), 80'(0));
      chk("hold_outputs", 80'({out_valid, out_a, out_b, out_op, out_rd}),
          80'({1'b1, 32'h0F0F, 32'h00FF, 3'd7, 5'd18}));
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    idle();
    idle();

    // Flush while holding and offering: both instructions discarded.
    out_ready = 1'b0;
    send(OP, 3'd0, 1'b0, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 32'h0, 5'd20, mk(0, 0, 0, 0, 0, 0), 1'b0);
    in_valid = 1'b1; in_rd = 5'd21; flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 80'(out_valid), 80'(0));
    @(posedge clk); #2;
    out_ready = 1'b1;
    send(OP, 3'd6, 1'b0, 5'd1, 32'hA0, 5'd2, 32'h0B, 32'h0, 32'h0, 5'd22,
         mk(32'hA0, 32'h0B, 3'd6, 1'b0, 1'b0, 5'd22), 1'b1);
    idle();
    idle();

    // Reset during a hold returns every output to zero.
    out_ready = 1'b0;
    send(OP, 3'd5, 1'b1, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'h1F, 32'h0, 32'h0, 5'd23, mk(0, 0, 0, 0, 0, 0), 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #2;
    @(negedge clk);
    chk("reset_mid_hold", 80'({out_valid, out_a, out_b, out_op, out_arith, out_illegal, out_rd}), 80'(0));
    chk("reset_in_ready", 80'(in_ready), 80'(1));
    @(posedge clk); #2;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 80'(sb.size()), 80'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
